// File: rtl/pixel_packer_if.sv
// Stream bundles for pixel_packer: the 24-bit pixel input and the 32-bit AXI4-Stream output.
// pixel_in_if carries r/g/b/valid/ready; pixel_packer_if carries tdata/tvalid/tready/tlast/tuser.
interface pixel_in_if;
    logic [7:0] in_r;
    logic [7:0] in_g;
    logic [7:0] in_b;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_r, output in_g, output in_b, output in_valid, input in_ready);
    modport slave  (input in_r, input in_g, input in_b, input in_valid, output in_ready);
endinterface

interface pixel_packer_if;
    logic [31:0] out_stream_tdata;
    logic        out_stream_tvalid;
    logic        out_stream_tready;
    logic        out_stream_tlast;
    logic        out_stream_tuser;

    modport master (output out_stream_tdata, output out_stream_tvalid, input out_stream_tready,
                    output out_stream_tlast, output out_stream_tuser);
    modport slave  (input out_stream_tdata, input out_stream_tvalid, output out_stream_tready,
                    input out_stream_tlast, input out_stream_tuser);
endinterface

// File: rtl/pixel_packer.sv
// Packs 24-bit RGB pixels, four at a time, into three little-endian 32-bit AXI4-Stream words.
// Optional status outputs (frame_done, frame_count) are built when PIXEL_PACKER_STATUS_EN is defined.
module pixel_packer #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic           aclk,
    input  logic           areset,
    pixel_in_if.slave      pix,
    pixel_packer_if.master axis
`ifdef PIXEL_PACKER_STATUS_EN
    ,
    output logic           frame_done,
    output logic [15:0]    frame_count
`endif
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    phase_t        phase_r;
    phase_t        phase_nxt_s;
    logic [23:0]   pix_s;
    logic          tready_s;
    logic          out_free_s;
    logic          in_ready_s;
    logic          emit_s;
    logic          accept_s;
    logic          load_s;
    logic [31:0]   word_s;
    logic [23:0]   residual_nxt_s;
    logic [23:0]   residual_r;
    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic          line_end_s;
    logic          frame_start_s;
    logic [31:0]   tdata_r;
    logic          tvalid_r;
    logic          tlast_r;
    logic          tuser_r;

    assign pix_s         = {pix.in_r, pix.in_g, pix.in_b};
    assign tready_s      = axis.out_stream_tready;
    assign out_free_s    = !tvalid_r || tready_s;
    assign accept_s      = pix.in_valid && in_ready_s;
    assign load_s        = accept_s && emit_s;
    assign line_end_s    = (x_r == X_LAST);
    assign frame_start_s = (x_r == X_ONE) && (y_r == {YW{1'b0}});

    assign pix.in_ready           = in_ready_s;
    assign axis.out_stream_tdata  = tdata_r;
    assign axis.out_stream_tvalid = tvalid_r;
    assign axis.out_stream_tlast  = tlast_r;
    assign axis.out_stream_tuser  = tuser_r;

    // Phase state register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            phase_r <= PH0;
        end else begin
            phase_r <= phase_nxt_s;
        end
    end

    // Phase advances by one on every accepted pixel.
    always_comb begin
        phase_nxt_s = phase_r;
        if (accept_s) begin
            case (phase_r)
                PH0:     phase_nxt_s = PH1;
                PH1:     phase_nxt_s = PH2;
                PH2:     phase_nxt_s = PH3;
                PH3:     phase_nxt_s = PH0;
                default: phase_nxt_s = PH0;
            endcase
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Per-phase ready, word assembly and residual carry; phase 0 only stores, so it never waits.
    always_comb begin
        in_ready_s     = 1'b1;
        emit_s         = 1'b0;
        word_s         = 32'h0000_0000;
        residual_nxt_s = residual_r;
        case (phase_r)
            PH0: begin
                in_ready_s     = 1'b1;
                emit_s         = 1'b0;
                word_s         = 32'h0000_0000;
                residual_nxt_s = pix_s;
            end
            PH1: begin
                in_ready_s     = out_free_s;
                emit_s         = 1'b1;
                word_s         = {pix_s[7:0], residual_r[23:0]};
                residual_nxt_s = {8'h00, pix_s[23:8]};
            end
            PH2: begin
                in_ready_s     = out_free_s;
                emit_s         = 1'b1;
                word_s         = {pix_s[15:0], residual_r[15:0]};
                residual_nxt_s = {16'h0000, pix_s[23:16]};
            end
            PH3: begin
                in_ready_s     = out_free_s;
                emit_s         = 1'b1;
                word_s         = {pix_s[23:0], residual_r[7:0]};
                residual_nxt_s = 24'h00_0000;
            end
            default: begin
                in_ready_s     = 1'b1;
                emit_s         = 1'b0;
                word_s         = 32'h0000_0000;
                residual_nxt_s = 24'h00_0000;
            end
        endcase
    end

    // Residual bytes carried from one pixel to the next within a group.
    always_ff @(posedge aclk) begin
        if (areset) begin
            residual_r <= 24'h00_0000;
        end else if (accept_s) begin
            residual_r <= residual_nxt_s;
        end else begin
            residual_r <= residual_r;
        end
    end

    // Pixel position within the frame, advanced on each accepted pixel.
    always_ff @(posedge aclk) begin
        if (areset) begin
            x_r <= {XW{1'b0}};
            y_r <= {YW{1'b0}};
        end else if (accept_s) begin
            if (line_end_s) begin
                x_r <= {XW{1'b0}};
                y_r <= (y_r == Y_LAST) ? {YW{1'b0}} : (y_r + YW'(1));
            end else begin
                x_r <= x_r + XW'(1);
            end
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

    // Output word register; a load can coincide with a handshake, keeping tvalid high.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tdata_r  <= 32'h0000_0000;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            tuser_r  <= 1'b0;
        end else if (load_s) begin
            tdata_r  <= word_s;
            tvalid_r <= 1'b1;
            tlast_r  <= line_end_s;
            tuser_r  <= frame_start_s;
        end else if (tready_s) begin
            tvalid_r <= 1'b0;
        end else begin
            tvalid_r <= tvalid_r;
        end
    end

`ifdef PIXEL_PACKER_STATUS_EN
    logic        frame_end_s;
    logic        fend_r;
    logic        frame_done_r;
    logic [15:0] frame_count_r;

    assign frame_end_s = line_end_s && (y_r == Y_LAST);
    assign frame_done  = frame_done_r;
    assign frame_count = frame_count_r;

    // Marks the pending word as the last one of a frame.
    always_ff @(posedge aclk) begin
        if (areset) begin
            fend_r <= 1'b0;
        end else if (load_s) begin
            fend_r <= frame_end_s;
        end else begin
            fend_r <= fend_r;
        end
    end

    // One-cycle pulse and wrapping count after the final word of a frame is handed off.
    always_ff @(posedge aclk) begin
        if (areset) begin
            frame_done_r  <= 1'b0;
            frame_count_r <= 16'h0000;
        end else if (tvalid_r && tready_s && fend_r) begin
            frame_done_r  <= 1'b1;
            frame_count_r <= frame_count_r + 16'd1;
        end else begin
            frame_done_r  <= 1'b0;
            frame_count_r <= frame_count_r;
        end
    end
`endif

endmodule

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
- Sits directly downstream of the pixel buffer. Consumes its 24-bit RGB pixel stream (r/g/b plus valid, with a ready output).
- Packs every 4 pixels into 3 little-endian 32-bit words on an AXI4-Stream master, for the video DMA.
- Tracks x/y position to generate tuser (start of frame) and tlast (end of line).

Parameters:
- X_SIZE, 640, pixels per line; must be a multiple of 4 and at least 4.
- Y_SIZE, 480, lines per frame; at least 1.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- in_r  in  8  pixel red.
- in_g  in  8  pixel green.
- in_b  in  8  pixel blue.
- in_valid  in  1  pixel present; a pixel is accepted when in_valid && in_ready.
- in_ready  out  1  packer can accept a pixel this cycle.
- out_stream_tdata  out  32  packed word.
- out_stream_tvalid  out  1  word valid.
- out_stream_tready  in  1  downstream accepts the word.
- out_stream_tlast  out  1  last word of a line.
- out_stream_tuser  out  1  first word of a frame.

Behaviour:
- Pixel value: P = {in_r, in_g, in_b} (24 bits). phase (2 bits) counts pixels within a group of 4.
- On each accepted pixel, by phase:
  - 0: residual <= P; no word emitted.
  - 1: emit {P[7:0], residual[23:0]}; residual <= P[23:8].
  - 2: emit {P[15:0], residual[15:0]}; residual <= P[23:16].
  - 3: emit {P[23:0], residual[7:0]}; residual cleared.
- phase increments mod 4 on every accept.
- Output register: tdata/tvalid/tlast/tuser are registered. An emitted word appears the cycle after acceptance (latency 1).
- While tvalid && !tready, tdata/tlast/tuser are held stable.
- tvalid drops after a handshake unless a new word is loaded in the same cycle.
- in_ready:
  - phase 0: in_ready = 1 (no output needed).
  - otherwise: in_ready = !out_stream_tvalid || out_stream_tready.
  - in_ready never depends combinationally on in_valid, since the upstream valid is gated by ready.
- Simultaneous handshake and load: when the output handshakes in the same cycle a phase 1–3 pixel is accepted, the new word loads and tvalid stays 1. Full throughput is 1 pixel/cycle.
- Counters update on every accepted pixel:
  - x: 0..X_SIZE-1; wraps to 0 and increments y.
  - y: 0..Y_SIZE-1; wraps to 0 at end of frame.
- tlast = 1 on the word emitted with pixel x == X_SIZE-1 (always phase 3). Lines end on word boundaries: 3*X_SIZE/4 words per line.
- tuser = 1 on the word emitted with pixel x == 1, y == 0 (first word of frame); 0 otherwise.
- Reset, including mid-frame or mid-group: next cycle tvalid=0, tdata=0, tlast=0, tuser=0, phase=0, residual=0, x=0, y=0.
  - Any partial group or pending word is discarded.
  - The next accepted pixel is treated as pixel (0,0) of a new frame.
- in_ready is 1 during reset release because phase=0.
- No backpressure deadlock: a pending word is never overwritten without a handshake.

Optional Feature:
- Macro PIXEL_PACKER_STATUS_EN.
- When defined, adds:
  - output frame_done (1 bit): pulses high for exactly one cycle, the cycle after the handshake of the final word of a frame (tlast on line Y_SIZE-1).
  - output frame_count (16 bits): increments with each frame_done and wraps at 0xFFFF->0.
  - Both reset to 0.
- When not defined, these ports and their logic do not exist and behaviour is otherwise identical.

Test Plan (X_SIZE=8, Y_SIZE=2 unless noted):
- Packing:
  - Stimulus: pixels 0x112233, 0x445566, 0x778899, 0xAABBCC back-to-back with tready=1.
  - Required: words 0x66112233, 0x88994455, 0xAABBCC77 on consecutive cycles, first with tuser=1; in_ready constant 1.
- Line/frame framing:
  - Stimulus: 16 pixels streamed with tready=1.
  - Required: 12 words; tlast on words 6 and 12; tuser only on word 1. Pixels 17–20 produce a word with tuser=1 again.
- Backpressure:
  - Stimulus: hold tready=0 after the first word is emitted.
  - Required: tdata stays 0x66112233 with tvalid=1. in_ready=0 at phase 2 and does not accept pixel 0x778899 until tready=1. No word is lost or duplicated.
- Bubbles:
  - Stimulus: in_valid toggled 1/0 every cycle.
  - Required: same word sequence as the packing test, and tvalid never asserted without a new word.
- Reset mid-group:
  - Stimulus: accept 2 pixels, assert areset for 1 cycle, then send 4 fresh pixels.
  - Required: tvalid=0 the cycle after reset. The first post-reset word has tuser=1 and contains only post-reset data.
- With PIXEL_PACKER_STATUS_EN:
  - Stimulus: stream two full frames.
  - Required: frame_done pulses exactly twice, one cycle after each final tlast handshake; frame_count reads 2.
